// File: rtl/snake_pkg.sv
// Shared types and helpers for the LED-matrix scan receive path.
// Coordinates are packed {x[7:4], y[3:0]}; strobes are active-low one-hot.
package snake_pkg;

  localparam int MATRIX_DIM = 16;
  localparam logic [MATRIX_DIM-1:0] ONEHOT_IDLE = 16'hFFFF;

  typedef logic [7:0] coord_t;

  typedef enum logic [1:0] {
    SAMPLE_IDLE,
    SAMPLE_POINT,
    SAMPLE_ERROR
  } sample_class_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } onehot_idx_t;

  // valid only when exactly one strobe line is pulled low
  function automatic onehot_idx_t onehot_n_to_idx(input logic [MATRIX_DIM-1:0] strobe);
    onehot_idx_t result;
    int unsigned lowCount;
    result   = '0;
    lowCount = 0;
    for (int i = 0; i < MATRIX_DIM; i++) begin
      if (!strobe[i]) begin
        lowCount++;
        result.idx = 4'(i);
      end
    end
    result.valid = (lowCount == 1);
    return result;
  endfunction

endpackage

// File: rtl/coord_fifo.sv
// Synchronous point FIFO; head is combinational and reads as zero while empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module coord_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   Clk,
  input  logic   rst,
  input  logic   push,
  input  coord_t pushData,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output coord_t headData
);

  localparam int AW = $clog2(DEPTH);

  coord_t       mem [DEPTH];
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  logic         doPush;
  logic         doPop;

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = empty ? '0 : mem[rdPtr[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/matrix_scan_encoder.sv
// Receive side of the 16x16 matrix scan: encodes lit points into a FIFO stream
// and accumulates a per-window 256-bit frame bitmap.
module matrix_scan_encoder
  import snake_pkg::*;
#(
  parameter int FRAME_CYC  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             Clk,
  input  logic                             rst,
  input  logic [MATRIX_DIM-1:0]            row,
  input  logic [MATRIX_DIM-1:0]            col,
  input  logic                             in_en,
  output logic [7:0]                       pt_data,
  output logic                             pt_valid,
  input  logic                             pt_ready,
  output logic [MATRIX_DIM*MATRIX_DIM-1:0] frame_bits,
  output logic                             frame_valid,
  output logic [8:0]                       frame_pts,
  output logic [7:0]                       err_cnt,
  output logic                             ovf
);

  localparam int FRAME_BITS = MATRIX_DIM * MATRIX_DIM;

  logic [MATRIX_DIM-1:0] rowQ, colQ;
  logic                  enQ;
  onehot_idx_t           rowIdx, colIdx;
  sample_class_t         sampleClass;
  coord_t                sampleCoord;

  logic                  s2En;
  sample_class_t         s2Class;
  coord_t                s2Coord;

  // NOTE: every clocked process uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      rowQ <= ONEHOT_IDLE;
      colQ <= ONEHOT_IDLE;
      enQ  <= 1'b0;
    end else begin
      rowQ <= row;
      colQ <= col;
      enQ  <= in_en;
    end
  end

  // NOTE: outputs get defaults first so no path through this block can infer a latch.
  always_comb begin
    rowIdx      = onehot_n_to_idx(rowQ);
    colIdx      = onehot_n_to_idx(colQ);
    sampleCoord = {4'd15 - colIdx.idx, 4'd15 - rowIdx.idx};
    sampleClass = SAMPLE_ERROR;
    if (rowQ == ONEHOT_IDLE && colQ == ONEHOT_IDLE) sampleClass = SAMPLE_IDLE;
    else if (rowIdx.valid && colIdx.valid)          sampleClass = SAMPLE_POINT;
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      s2En    <= 1'b0;
      s2Class <= SAMPLE_IDLE;
      s2Coord <= '0;
    end else begin
      s2En    <= enQ;
      s2Class <= sampleClass;
      s2Coord <= sampleCoord;
    end
  end

  logic   isPoint, isError, pushReq, popFire;
  logic   prevPoint, lastValid;
  coord_t lastCoord;
  logic   fifoFull, fifoEmpty;

  assign isPoint = s2En && (s2Class == SAMPLE_POINT);
  assign isError = s2En && (s2Class == SAMPLE_ERROR);
  // a held strobe repeats the same point every cycle; only its first sample is streamed
  assign pushReq = isPoint && (!prevPoint || !lastValid || s2Coord != lastCoord);
  assign popFire = pt_valid && pt_ready;
  assign pt_valid = !fifoEmpty;

  always_ff @(posedge Clk) begin
    if (!rst) begin
      prevPoint <= 1'b0;
      lastValid <= 1'b0;
      lastCoord <= '0;
      err_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      if (s2En) prevPoint <= (s2Class == SAMPLE_POINT);
      if (pushReq) begin
        lastCoord <= s2Coord;
        lastValid <= 1'b1;
      end
      if (isError && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (pushReq && fifoFull && !popFire) ovf <= 1'b1;
    end
  end

  coord_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk      (Clk),
    .rst      (rst),
    .push     (pushReq),
    .pushData (s2Coord),
    .pop      (pt_ready),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .headData (pt_data)
  );

  logic [15:0]           winCnt;
  logic [FRAME_BITS-1:0] acc;
  logic [FRAME_BITS-1:0] ptMask;
  logic [8:0]            distinct;
  logic                  newBit;

  assign ptMask = isPoint ? (FRAME_BITS'(1) << s2Coord) : '0;
  assign newBit = isPoint && !acc[s2Coord];

  always_ff @(posedge Clk) begin
    if (!rst) begin
      winCnt      <= '0;
      acc         <= '0;
      distinct    <= '0;
      frame_bits  <= '0;
      frame_pts   <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (s2En) begin
        if (winCnt == 16'(FRAME_CYC - 1)) begin
          // the terminal sample's point belongs to the frame being closed
          frame_bits  <= acc | ptMask;
          frame_pts   <= distinct + 9'(newBit);
          frame_valid <= 1'b1;
          acc         <= '0;
          distinct    <= '0;
          winCnt      <= '0;
        end else begin
          acc      <= acc | ptMask;
          distinct <= distinct + 9'(newBit);
          winCnt   <= winCnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_encoder.sv
// Scoreboard bench for matrix_scan_encoder: a behavioural model queues expected points
// and frames at stimulus time; a negedge monitor pops and compares as the DUT presents them.
module tb_matrix_scan_encoder;

  localparam int FRAME_CYC  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam logic [15:0] IDLE = 16'hFFFF;

  logic         Clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  row = IDLE;
  logic [15:0]  col = IDLE;
  logic         in_en = 1'b0;
  logic         pt_ready = 1'b0;
  logic [7:0]   pt_data;
  logic         pt_valid;
  logic [255:0] frame_bits;
  logic         frame_valid;
  logic [8:0]   frame_pts;
  logic [7:0]   err_cnt;
  logic         ovf;

  matrix_scan_encoder #(.FRAME_CYC(FRAME_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clk(Clk), .rst(rst), .row(row), .col(col), .in_en(in_en),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .frame_bits(frame_bits), .frame_valid(frame_valid), .frame_pts(frame_pts),
    .err_cnt(err_cnt), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    logic [255:0] bits;
    int           pts;
  } frame_t;

  logic [7:0]   expQ[$];
  frame_t       frameQ[$];
  logic         mPrevPoint, mLastValid, expOvf;
  logic [7:0]   mLast;
  logic [255:0] mSet;
  int           mWin, expErr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] strobe_for(input int k);
    logic [15:0] s;
    s = 16'h8000 >> k;
    return ~s;
  endfunction

  task automatic model_reset();
    expQ.delete();
    frameQ.delete();
    mPrevPoint = 1'b0;
    mLastValid = 1'b0;
    mLast      = '0;
    mSet       = '0;
    mWin       = 0;
    expErr     = 0;
    expOvf     = 1'b0;
  endtask

  // Reference behaviour of one sampled cycle, written from the interface rules.
  task automatic model_sample(input logic [15:0] r, input logic [15:0] c, input logic en);
    int nr, nc, xi, yi;
    logic isPt;
    logic [7:0] pt;
    if (!en) return;
    nr = $countones(~r);
    nc = $countones(~c);
    isPt = 1'b0;
    pt = '0;
    xi = 0;
    yi = 0;
    if (nr == 1 && nc == 1) begin
      for (int i = 0; i < 16; i++) begin
        if (!c[i]) xi = 15 - i;
        if (!r[i]) yi = 15 - i;
      end
      isPt = 1'b1;
      pt = {4'(xi), 4'(yi)};
    end else if (!(nr == 0 && nc == 0)) begin
      if (expErr < 255) expErr++;
    end
    if (isPt) begin
      if (!mPrevPoint || !mLastValid || pt != mLast) begin
        if (expQ.size() >= FIFO_DEPTH) expOvf = 1'b1;
        else expQ.push_back(pt);
        mLast = pt;
        mLastValid = 1'b1;
      end
      mSet[pt] = 1'b1;
    end
    mPrevPoint = isPt;
    mWin++;
    if (mWin == FRAME_CYC) begin
      frameQ.push_back('{mSet, $countones(mSet)});
      mSet = '0;
      mWin = 0;
    end
  endtask

  task automatic step(input logic [15:0] r, input logic [15:0] c, input logic en, input logic rdy);
    @(posedge Clk);
    #1;
    row = r;
    col = c;
    in_en = en;
    pt_ready = rdy;
    model_sample(r, c, en);
  endtask

  task automatic put_pt(input logic [7:0] p, input logic rdy);
    step(strobe_for(int'(p[3:0])), strobe_for(int'(p[7:4])), 1'b1, rdy);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    rst = 1'b0;
    row = IDLE;
    col = IDLE;
    in_en = 1'b0;
    pt_ready = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    rst = 1'b1;
    @(negedge Clk);
    #1;
    check("rst_pt_valid", pt_valid, 0);
    check("rst_pt_data", pt_data, 0);
    check("rst_frame_bits", frame_bits, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_pts", frame_pts, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_ovf", ovf, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expQ.size() != 0; i++) step(IDLE, IDLE, 1'b1, 1'b1);
    repeat (4) step(IDLE, IDLE, 1'b0, 1'b1);
    @(negedge Clk);
    #1;
    check("drain_points_left", expQ.size(), 0);
    check("drain_frames_left", frameQ.size(), 0);
    check("err_cnt", err_cnt, expErr);
    check("ovf", ovf, expOvf);
  endtask

  logic       holdValid = 1'b0;
  logic [7:0] holdData = '0;

  always @(negedge Clk) begin
    if (!rst) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        check("pt_valid_held", pt_valid, 1);
        check("pt_data_stable", pt_data, holdData);
      end
      if (pt_valid && pt_ready) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("FAIL pt_unexpected: got %0h expected none", pt_data);
        end else begin
          check("pt_data", pt_data, expQ.pop_front());
        end
      end
      holdValid = pt_valid && !pt_ready;
      holdData  = pt_data;
      if (frame_valid) begin
        if (frameQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("FAIL frame_unexpected: got pts %0d expected none", frame_pts);
        end else begin
          frame_t f;
          f = frameQ.pop_front();
          check("frame_bits", frame_bits, f.bits);
          check("frame_pts", frame_pts, f.pts);
        end
      end
    end
  end

  initial begin
    logic [255:0] expBits;
    logic [7:0]   lastRand;
    model_reset();
    do_reset();

    // window of 8: 25,35,25,9E then idle; next window all idle
    put_pt(8'h25, 1'b1);
    put_pt(8'h35, 1'b1);
    put_pt(8'h25, 1'b1);
    put_pt(8'h9E, 1'b1);
    repeat (4) step(IDLE, IDLE, 1'b1, 1'b1);
    repeat (3) step(IDLE, IDLE, 1'b1, 1'b1);
    @(negedge Clk);
    #1;
    expBits = '0;
    expBits[8'h25] = 1'b1;
    expBits[8'h35] = 1'b1;
    expBits[8'h9E] = 1'b1;
    check("t3_frame_bits", frame_bits, expBits);
    check("t3_frame_pts", frame_pts, 3);
    repeat (5) step(IDLE, IDLE, 1'b1, 1'b1);
    repeat (3) step(IDLE, IDLE, 1'b0, 1'b1);
    @(negedge Clk);
    #1;
    check("t3_empty_bits", frame_bits, 0);
    check("t3_empty_pts", frame_pts, 0);
    drain();

    // single point latency: sampled at edge N, presented after edge N+2
    step(~16'h0400, ~16'h2000, 1'b1, 1'b1);
    step(IDLE, IDLE, 1'b1, 1'b1);
    step(IDLE, IDLE, 1'b1, 1'b1);
    @(negedge Clk);
    #1;
    check("t1_valid_early", pt_valid, 0);
    step(IDLE, IDLE, 1'b1, 1'b1);
    @(negedge Clk);
    #1;
    check("t1_valid", pt_valid, 1);
    check("t1_data", pt_data, 8'h25);
    step(IDLE, IDLE, 1'b1, 1'b1);
    @(negedge Clk);
    #1;
    check("t1_single_pop", pt_valid, 0);
    drain();

    // held strobe collapses to one push per hold
    repeat (5) put_pt(8'h25, 1'b1);
    step(IDLE, IDLE, 1'b1, 1'b1);
    put_pt(8'h25, 1'b1);
    drain();

    // malformed samples
    step(~16'h0006, strobe_for(5), 1'b1, 1'b1);
    step(IDLE, strobe_for(5), 1'b1, 1'b1);
    drain();
    check("t4_err_cnt", err_cnt, 2);

    // randomized traffic, throttled so the FIFO can never overflow
    lastRand = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic rdy;
      logic [7:0] p;
      sel = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 9) < 7);
      if (expQ.size() >= FIFO_DEPTH) begin
        step(IDLE, IDLE, 1'b1, rdy);
      end else if (sel < 45) begin
        p = ($urandom_range(0, 2) == 0) ? lastRand : 8'($urandom);
        lastRand = p;
        put_pt(p, rdy);
      end else if (sel < 65) begin
        step(IDLE, IDLE, 1'b1, rdy);
      end else if (sel < 80) begin
        step(16'($urandom), 16'($urandom), 1'b1, rdy);
      end else begin
        step(16'($urandom), 16'($urandom), 1'b0, rdy);
      end
    end
    drain();

    // error counter saturation
    repeat (300) step(~16'h0006, strobe_for(1), 1'b1, 1'b1);
    drain();
    check("sat_err_cnt", err_cnt, 8'hFF);

    // backpressure: 10 distinct points into an 8-deep FIFO
    for (int k = 1; k <= 10; k++) put_pt({4'(k), 4'(k)}, 1'b0);
    repeat (4) step(IDLE, IDLE, 1'b0, 1'b0);
    @(negedge Clk);
    #1;
    check("t5_ovf", ovf, 1);
    check("t5_valid", pt_valid, 1);
    check("t5_head", pt_data, 8'h11);
    drain();

    // reset in the middle of a frame
    put_pt(8'h25, 1'b1);
    put_pt(8'h35, 1'b1);
    put_pt(8'h9E, 1'b1);
    do_reset();
    put_pt(8'h25, 1'b1);
    repeat (7) step(IDLE, IDLE, 1'b1, 1'b1);
    put_pt(8'h9E, 1'b1);
    repeat (3) step(IDLE, IDLE, 1'b0, 1'b1);
    @(negedge Clk);
    #1;
    expBits = '0;
    expBits[8'h25] = 1'b1;
    check("t6_frame_bits", frame_bits, expBits);
    check("t6_frame_pts", frame_pts, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
